// File: rtl/serial_adder_if.sv
// Operand/result bundle between a serial_adder and its requester.
// The master drives the request fields; the slave returns status and the registered result.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle add/subtract, STEP bits per cycle LSB first; result ready WIDTH/STEP cycles after start.
// start is ignored while busy; a start in the done cycle chains straight into the next operation.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic          clk,
    input  logic          reset,
    serial_adder_if.slave bus
);
    if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
        $error("serial_adder: WIDTH must be in 2..64");
    end
    if (STEP < 1 || (WIDTH % STEP) != 0) begin : g_bad_step
        $error("serial_adder: WIDTH must be a multiple of STEP");
    end

    localparam int N     = WIDTH / STEP;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;

    logic [STEP-1:0]    step_a, step_b, step_s;
    logic [STEP:0]      step_res;
    logic               step_c;
    logic               accept;

    always_comb begin
        step_a   = a_q[STEP-1:0];
        step_b   = b_q[STEP-1:0];
        step_res = {1'b0, step_a} + {1'b0, step_b} + {{STEP{1'b0}}, carry_q};
        step_s   = step_res[STEP-1:0];
        step_c   = step_res[STEP];
        accept   = bus.start && (state_q != RUN);

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        if (state_q == RUN) begin
            a_d     = a_q >> STEP;
            b_d     = b_q >> STEP;
            carry_d = step_c;
            // Partial sum enters at the top so the final step leaves it LSB-aligned.
            acc_d   = (acc_q >> STEP) | (WIDTH'(step_s) << (WIDTH - STEP));
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(N - 1)) begin
                state_d = DONE;
                sum_d   = acc_d;
                cout_d  = step_c;
                // Carry into the MSB is recovered from the MSB sum bit.
                ovf_d   = step_a[STEP-1] ^ step_b[STEP-1] ^ step_s[STEP-1] ^ step_c;
            end
        end else if (accept) begin
            state_d = RUN;
            a_d     = bus.a;
            b_d     = bus.b ^ {WIDTH{bus.sub}};
            carry_d = bus.cin ^ bus.sub;
            cnt_d   = '0;
            acc_d   = '0;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy     = (state_q == RUN);
    assign bus.done     = (state_q == DONE);
    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit/1-bit-step instance and a 16-bit/4-bit-step instance.
module tb_serial_adder;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    serial_adder_if #(.WIDTH(8))  bus8 ();
    serial_adder_if #(.WIDTH(16)) bus16 ();

    serial_adder #(.WIDTH(8),  .STEP(1)) dut8  (.clk(clk), .reset(reset), .bus(bus8));
    serial_adder #(.WIDTH(16), .STEP(4)) dut16 (.clk(clk), .reset(reset), .bus(bus16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Launch one 8-bit operation, count busy cycles, then check the done cycle and result.
    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic sub,
                       input logic [7:0] e_sum, input logic e_cout, input logic e_ovf);
        int n;
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.cin = cin; bus8.sub = sub;
        @(negedge clk);
        bus8.start = 1'b0; bus8.a = ~a; bus8.b = ~b;
        n = 0;
        while (bus8.busy && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, 64'(n), 64'd8);
        chk({tag, "_done"}, 64'(bus8.done), 64'd1);
        chk({tag, "_excl"}, 64'(bus8.busy), 64'd0);
        chk({tag, "_sum"}, 64'(bus8.sum), 64'(e_sum));
        chk({tag, "_cout"}, 64'(bus8.cout), 64'(e_cout));
        chk({tag, "_ovf"}, 64'(bus8.overflow), 64'(e_ovf));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(bus8.done), 64'd0);
        chk({tag, "_hold"}, 64'(bus8.sum), 64'(e_sum));
    endtask

    task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub,
                        input logic [15:0] e_sum, input logic e_cout, input logic e_ovf);
        int n;
        @(negedge clk);
        bus16.start = 1'b1; bus16.a = a; bus16.b = b; bus16.cin = cin; bus16.sub = sub;
        @(negedge clk);
        bus16.start = 1'b0;
        n = 0;
        while (bus16.busy && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, 64'(n), 64'd4);
        chk({tag, "_done"}, 64'(bus16.done), 64'd1);
        chk({tag, "_sum"}, 64'(bus16.sum), 64'(e_sum));
        chk({tag, "_cout"}, 64'(bus16.cout), 64'(e_cout));
        chk({tag, "_ovf"}, 64'(bus16.overflow), 64'(e_ovf));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(bus16.done), 64'd0);
    endtask

    initial begin
        int n;
        int seen;
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0; bus8.sub = 1'b0;
        bus16.start = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.sub = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(bus8.busy), 64'd0);
        chk("rst_done", 64'(bus8.done), 64'd0);
        chk("rst_sum", 64'(bus8.sum), 64'd0);
        chk("rst_flags", 64'({bus8.cout, bus8.overflow}), 64'd0);
        chk("rst_busy16", 64'(bus16.busy), 64'd0);
        reset = 1'b0;

        op8("add_basic", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
        op8("add_carry", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
        op8("add_ovf",   8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        op8("sub_borrow", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        op8("sub_ovf",   8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
        op8("sub_cin",   8'h10, 8'h03, 1'b1, 1'b1, 8'h0C, 1'b1, 1'b0);

        // Start ignored during RUN, then back-to-back start in the done cycle.
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'h01; bus8.b = 8'h01; bus8.cin = 1'b0; bus8.sub = 1'b0;
        @(negedge clk);
        bus8.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'hAA;
        @(negedge clk);
        bus8.start = 1'b0;
        n = 3;
        while (bus8.busy && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("ignore_busy_cycles", 64'(n), 64'd8);
        chk("ignore_done", 64'(bus8.done), 64'd1);
        chk("ignore_sum", 64'(bus8.sum), 64'h02);
        bus8.start = 1'b1; bus8.a = 8'h03; bus8.b = 8'h04; bus8.cin = 1'b0; bus8.sub = 1'b0;
        @(negedge clk);
        bus8.start = 1'b0;
        chk("b2b_busy", 64'(bus8.busy), 64'd1);
        chk("b2b_done", 64'(bus8.done), 64'd0);
        n = 0;
        while (bus8.busy && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("b2b_busy_cycles", 64'(n), 64'd8);
        chk("b2b_sum", 64'(bus8.sum), 64'h07);

        // Reset in RUN cycle 4 aborts the operation.
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'h33; bus8.b = 8'h22;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_pre_busy", 64'(bus8.busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 64'(bus8.busy), 64'd0);
        chk("abort_sum", 64'(bus8.sum), 64'h00);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus8.done || bus8.busy) seen++;
        end
        chk("abort_no_done", 64'(seen), 64'd0);

        // Reset wins over a simultaneous start.
        reset = 1'b1; bus8.start = 1'b1;
        @(negedge clk);
        reset = 1'b0; bus8.start = 1'b0;
        chk("rst_prio_busy", 64'(bus8.busy), 64'd0);

        op16("w16_add", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);
        op16("w16_sub", 16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        op16("w16_carry", 16'hFFFF, 16'h8000, 1'b1, 1'b0, 16'h8000, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
